// File: rtl/wb_sequencer.sv
// Writeback sequencer: selects ALU or memory writeback, issues memory strobes and
// stalls the front end while a load waits. Optional stall counter: WB_STALL_CNT_EN.
module wb_sequencer #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  wr_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] dest_out
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("wb_sequencer: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic                    lat_wr, lat_wr_n;
  logic [REG_ADDR_W-1:0]   lat_dest, lat_dest_n;
  logic                    stall_n, mem_read_n, mem_write_n, mem_to_reg_n, reg_write_n;
  logic [REG_ADDR_W-1:0]   dest_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_wr     <= 1'b0;
      lat_dest   <= '0;
      stall      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      dest_out   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat_wr     <= lat_wr_n;
      lat_dest   <= lat_dest_n;
      stall      <= stall_n;
      mem_read   <= mem_read_n;
      mem_write  <= mem_write_n;
      mem_to_reg <= mem_to_reg_n;
      reg_write  <= reg_write_n;
      dest_out   <= dest_n;
    end
  end

  // Next-state and next-output logic; every output is the registered form of these.
  always_comb begin
    state_n      = IDLE;
    cnt_n        = cnt;
    lat_wr_n     = lat_wr;
    lat_dest_n   = lat_dest;
    stall_n      = 1'b0;
    mem_read_n   = 1'b0;
    mem_write_n  = 1'b0;
    mem_to_reg_n = 1'b0;
    reg_write_n  = 1'b0;
    dest_n       = dest_out;
    case (state)
      LOAD_WAIT: begin
        if (cnt == '0) begin
          state_n      = LOAD_WB;
          mem_to_reg_n = 1'b1;
          reg_write_n  = lat_wr;
          dest_n       = lat_dest;
        end else begin
          state_n = LOAD_WAIT;
          cnt_n   = cnt - 4'd1;
          stall_n = 1'b1;
        end
      end
      default: begin
        if (instr_valid) begin
          // A load wins over a simultaneous store; the store is dropped.
          if (is_load) begin
            state_n    = LOAD_WAIT;
            cnt_n      = 4'(MEM_LAT - 1);
            lat_wr_n   = wr_en_in;
            lat_dest_n = dest_in;
            mem_read_n = 1'b1;
            stall_n    = 1'b1;
          end else if (is_store) begin
            mem_write_n = 1'b1;
          end else begin
            reg_write_n = wr_en_in;
            dest_n      = dest_in;
          end
        end
      end
    endcase
  end

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
